crop_pixel_writer: RTL and testbench
====================================

Name: crop_pixel_writer

Overview:
- Downstream neighbour of the BMP header writer in the cropping path; starts once the header stage asserts done.
- Copies the cropped window [xMin..xMax] x [yMin..yMax] from the source frame buffer into the output BMP memory, starting at byte address 54.
- Output layout: rows stored bottom-up, pixel bytes in B,G,R order, each row zero-padded to a multiple of 4 bytes.

Parameters:
- WIDTH, 100, source image width in pixels.
- HEIGHT, 100, source image height in pixels.
- HDR_BYTES, 54, first output byte address; the header occupies 0..53.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a copy; sampled in IDLE and FINISHED only
- done  out  1  high while in FINISHED
- xMin, xMax, yMin, yMax  in  11 each  inclusive crop bounds, source pixel coordinates, row 0 = top
- src_addr  out  24  source pixel address = y*WIDTH + x
- src_rden  out  1  source read strobe
- src_rddata  in  24  {R[23:16], G[15:8], B[7:0]}; valid exactly 1 cycle after src_rden
- addr  out  24  output byte address
- wren  out  1  output write strobe
- wrdata  out  16  byte in [7:0]; [15:8] always 0

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-copy): state IDLE; done, wren, src_rden = 0; addr, wrdata, src_addr = 0; counters cleared. No partial writes after reset.
- Bounds are latched on the cycle start is accepted; input changes mid-copy are ignored.
- Width rules:
  - w = xMax-xMin+1, h = yMax-yMin+1.
  - rowBytes = 3*w; pad = (4 - (rowBytes mod 4)) mod 4, range 0..3.
  - Arithmetic is 24-bit unsigned; src_addr product uses 24 bits.
- Invalid bounds (xMax<xMin, yMax<yMin, xMax>=WIDTH, yMax>=HEIGHT): start moves directly to FINISHED with no writes.
- States and transitions:
  - IDLE: all outputs 0. start -> READ (valid bounds), setting y=yMax, x=xMin, out address counter = HDR_BYTES.
  - READ (1 cycle): src_rden=1, src_addr=y*WIDTH+x -> CAPTURE.
  - CAPTURE (1 cycle): register src_rddata -> WB.
  - WB, WG, WR (1 cycle each): wren=1, addr=counter, wrdata={8'h00, byte}. Counter increments after each write.
  - After WR:
    - if x<xMax: x++ -> READ.
    - else if pad>0: -> PAD.
    - else: row end.
  - PAD: writes 0x00 pad times, one byte per cycle -> row end.
  - Row end: if y>yMin: y--, x=xMin -> READ; else -> FINISHED.
  - FINISHED: done=1, wren=0, addr=0, wrdata=0. start -> restart as from IDLE. done drops on the cycle after start is accepted.
- start during READ..PAD is ignored.
- Cycle cost: 5 cycles per pixel + pad cycles per row. Total = h*(5w+pad) cycles from start acceptance to the first done cycle.
- Total bytes written = h*(rowBytes+pad), at contiguous addresses HDR_BYTES..HDR_BYTES+h*(rowBytes+pad)-1.
- wren and src_rden are never high in the same cycle.

Decomposition:
- Package crop_pkg:
  - HDR_BYTES=54 and BYTES_PER_PIXEL=3 constants.
  - State enum (IDLE, READ, CAPTURE, WB, WG, WR, PAD, FINISHED).
  - padded_row_bytes(w) function, shared with the header stage so both compute the identical padded width.
- Sub-module bmp_row_geometry: combinational w, h, rowBytes, pad, valid from the four bounds. Instantiated here and reusable by the header writer.

Test Plan:
- 1x1 crop at (0,0), src[0]=24'h112233 -> writes addr 54=0x33, 55=0x22, 56=0x11, 57=0x00 (pad 1). done high 6 cycles after start acceptance; no other writes.
- 2x2 crop xMin=1..2, yMin=1..2, WIDTH=100, src[y*100+x]=x+16*y:
  - First row read is y=2; rowBytes 6, pad 2, 16 bytes at 54..69.
  - addr 54=0x21 (B of (1,2)), 62=0x11 (B of (1,1)), 60/61/68/69=0x00.
- 4-pixel-wide crop (rowBytes 12, pad 0) -> no PAD state entered; last write addr = 54+12h-1.
- Invalid bounds xMin=5, xMax=4 -> zero wren cycles; done the cycle after start.
- rst_n low during the third WG write -> next cycle all outputs 0, state IDLE. A subsequent start redoes the full copy from addr 54.
- Second start while in FINISHED with new bounds -> done falls; the full new image is written from addr 54 with the new geometry.

Source files
------------

// File: rtl/crop_pixel_writer_pkg.sv
// Shared constants, state encoding and padded-row helper for the BMP cropping path.
// The header writer uses padded_row_bytes() too, so both stages agree on the row stride.
package crop_pkg;

  localparam int HDR_BYTES       = 54;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WB,
    WG,
    WR,
    PAD,
    FINISHED
  } state_t;

  // BMP rows are stored rounded up to a whole number of 32-bit words
  function automatic logic [23:0] padded_row_bytes(input logic [23:0] w);
    logic [23:0] rb;
    rb = w * 24'(BYTES_PER_PIXEL);
    return (rb + 24'd3) & ~24'd3;
  endfunction

endpackage

// File: rtl/crop_pixel_writer_if.sv
// Source frame-buffer read port and output BMP memory write port of the pixel writer.
interface crop_pixel_writer_if;

  logic [23:0] src_addr;
  logic        src_rden;
  logic [23:0] src_rddata;
  logic [23:0] addr;
  logic        wren;
  logic [15:0] wrdata;

  modport master (
    output src_addr, src_rden, addr, wren, wrdata,
    input  src_rddata
  );

  modport slave (
    input  src_addr, src_rden, addr, wren, wrdata,
    output src_rddata
  );

endinterface

// File: rtl/crop_pixel_writer_geometry.sv
// Combinational crop-window geometry: size, row byte count, row padding and bounds check.
module bmp_row_geometry
  import crop_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic [10:0] i_xmin,
  input  logic [10:0] i_xmax,
  input  logic [10:0] i_ymin,
  input  logic [10:0] i_ymax,
  output logic [23:0] o_w,
  output logic [23:0] o_h,
  output logic [23:0] o_row_bytes,
  output logic [1:0]  o_pad,
  output logic        o_valid
);

  assign o_w         = 24'(i_xmax) - 24'(i_xmin) + 24'd1;
  assign o_h         = 24'(i_ymax) - 24'(i_ymin) + 24'd1;
  assign o_row_bytes = o_w * 24'(BYTES_PER_PIXEL);
  assign o_pad       = 2'(padded_row_bytes(o_w) - o_row_bytes);

  assign o_valid = (i_xmax >= i_xmin) && (i_ymax >= i_ymin) &&
                   (24'(i_xmax) < 24'(WIDTH)) && (24'(i_ymax) < 24'(HEIGHT));

endmodule

// File: rtl/crop_pixel_writer.sv
// Copies a cropped window of the source frame into BMP pixel storage after the header:
// rows bottom-up, bytes B,G,R, each row zero-padded to a 4-byte multiple.
module crop_pixel_writer
  import crop_pkg::*;
#(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int HDR_BYTES = crop_pkg::HDR_BYTES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       done,
  input  logic [10:0]                xMin,
  input  logic [10:0]                xMax,
  input  logic [10:0]                yMin,
  input  logic [10:0]                yMax,
  crop_pixel_writer_if.master        bus
);

  state_t      r_state, w_next;

  logic [23:0] w_w, w_h, w_row_bytes;
  logic [1:0]  w_pad;
  logic        w_valid;

  logic [10:0] r_x, r_y, r_xmin;
  logic [23:0] r_cols_m1, r_col_left, r_row_left;
  logic [1:0]  r_pad, r_pad_left;
  logic [23:0] r_stride, r_row_base, r_offset;
  logic [23:0] r_pix;

  logic        w_last_col, w_more_rows, w_row_end;
  logic [23:0] w_addr;

  bmp_row_geometry #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_geom (
    .i_xmin      (xMin),
    .i_xmax      (xMax),
    .i_ymin      (yMin),
    .i_ymax      (yMax),
    .o_w         (w_w),
    .o_h         (w_h),
    .o_row_bytes (w_row_bytes),
    .o_pad       (w_pad),
    .o_valid     (w_valid)
  );

  assign w_last_col  = (r_col_left == 24'd0);
  assign w_more_rows = (r_row_left != 24'd0);
  assign w_row_end   = ((r_state == WR) && w_last_col && (r_pad == 2'd0)) ||
                       ((r_state == PAD) && (r_pad_left == 2'd1));
  // Address is row base plus offset so each row starts exactly one stride after the last
  assign w_addr      = r_row_base + r_offset;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    done           = 1'b0;
    bus.src_rden   = 1'b0;
    bus.src_addr   = 24'd0;
    bus.wren       = 1'b0;
    bus.addr       = 24'd0;
    bus.wrdata     = 16'd0;
    case (r_state)
      IDLE: begin
        if (start) w_next = w_valid ? READ : FINISHED;
      end
      READ: begin
        bus.src_rden = 1'b1;
        bus.src_addr = 24'(r_y) * 24'(WIDTH) + 24'(r_x);
        w_next       = CAPTURE;
      end
      CAPTURE: w_next = WB;
      WB: begin
        bus.wren   = 1'b1;
        bus.addr   = w_addr;
        bus.wrdata = {8'h00, r_pix[7:0]};
        w_next     = WG;
      end
      WG: begin
        bus.wren   = 1'b1;
        bus.addr   = w_addr;
        bus.wrdata = {8'h00, r_pix[15:8]};
        w_next     = WR;
      end
      WR: begin
        bus.wren   = 1'b1;
        bus.addr   = w_addr;
        bus.wrdata = {8'h00, r_pix[23:16]};
        if (!w_last_col)         w_next = READ;
        else if (r_pad != 2'd0)  w_next = PAD;
        else                     w_next = w_more_rows ? READ : FINISHED;
      end
      PAD: begin
        bus.wren = 1'b1;
        bus.addr = w_addr;
        if (r_pad_left == 2'd1) w_next = w_more_rows ? READ : FINISHED;
      end
      FINISHED: begin
        done = 1'b1;
        if (start) w_next = w_valid ? READ : FINISHED;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x        <= 11'd0;
      r_y        <= 11'd0;
      r_xmin     <= 11'd0;
      r_cols_m1  <= 24'd0;
      r_col_left <= 24'd0;
      r_row_left <= 24'd0;
      r_pad      <= 2'd0;
      r_pad_left <= 2'd0;
      r_stride   <= 24'd0;
      r_row_base <= 24'd0;
      r_offset   <= 24'd0;
    end else begin
      case (r_state)
        IDLE, FINISHED: begin
          if (start && w_valid) begin
            r_x        <= xMin;
            r_xmin     <= xMin;
            r_y        <= yMax;
            r_cols_m1  <= w_w - 24'd1;
            r_col_left <= w_w - 24'd1;
            r_row_left <= w_h - 24'd1;
            r_pad      <= w_pad;
            r_stride   <= w_row_bytes + {22'd0, w_pad};
            r_row_base <= 24'(HDR_BYTES);
            r_offset   <= 24'd0;
          end
        end
        CAPTURE: r_pix <= bus.src_rddata;
        WB, WG:  r_offset <= r_offset + 24'd1;
        WR: begin
          r_offset <= r_offset + 24'd1;
          if (!w_last_col) begin
            r_x        <= r_x + 11'd1;
            r_col_left <= r_col_left - 24'd1;
          end else begin
            r_pad_left <= r_pad;
          end
        end
        PAD: begin
          r_offset   <= r_offset + 24'd1;
          r_pad_left <= r_pad_left - 2'd1;
        end
        default: ;
      endcase
      // Next row up in the source is the next row in the bottom-up BMP
      if (w_row_end && w_more_rows) begin
        r_row_base <= r_row_base + r_stride;
        r_offset   <= 24'd0;
        r_x        <= r_xmin;
        r_y        <= r_y - 11'd1;
        r_col_left <= r_cols_m1;
        r_row_left <= r_row_left - 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_crop_pixel_writer.sv
// Bench for crop_pixel_writer: source memory model, write logger and a byte-list reference model.
module tb_crop_pixel_writer;

  localparam int BASE = 54;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;

  crop_pixel_writer_if bus();

  crop_pixel_writer #(.WIDTH(100), .HEIGHT(100), .HDR_BYTES(54)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .done  (done),
    .xMin  (xMin),
    .xMax  (xMax),
    .yMin  (yMin),
    .yMax  (yMax),
    .bus   (bus)
  );

  logic [23:0] mem [0:9999];
  logic [39:0] wlog [$];
  logic [7:0]  exp_q [$];
  int n_tests = 0, n_fail = 0, n_overlap = 0;

  typedef struct {
    int xa, xb, ya, yb;
    int cyc;
    int nbytes;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.src_rden) bus.src_rddata <= mem[bus.src_addr];

  always @(negedge clk) begin
    if (bus.wren) wlog.push_back({bus.addr, bus.wrdata});
    if (bus.wren && bus.src_rden) n_overlap++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected output bytes listed in storage order, plus the cycle cost they imply
  task automatic model(input int xa, xb, ya, yb, output int cyc);
    exp_q.delete();
    cyc = 0;
    if (xb < xa || yb < ya || xb >= 100 || yb >= 100) return;
    for (int y = yb; y >= ya; y--) begin
      int nb;
      nb = 0;
      for (int x = xa; x <= xb; x++) begin
        logic [23:0] p;
        p = mem[y*100 + x];
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[23:16]);
        nb += 3;
        cyc += 5;
      end
      while (nb % 4 != 0) begin
        exp_q.push_back(8'h00);
        nb++;
        cyc++;
      end
    end
  endtask

  task automatic run_copy(input int xa, xb, ya, yb, input bit noise, output int cyc);
    @(negedge clk);
    wlog.delete();
    xMin = 11'(xa); xMax = 11'(xb); yMin = 11'(ya); yMax = 11'(yb);
    start = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k - 1;
        start = 1'b0;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        xMin = 11'($urandom_range(0, 120)); xMax = 11'($urandom_range(0, 120));
        yMin = 11'($urandom_range(0, 120)); yMax = 11'($urandom_range(0, 120));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, " nbytes"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 64'(wlog[i]), 64'({24'(BASE + i), 8'h00, exp_q[i]}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, mcyc;
    bit found;

    vt[0] = '{0, 0, 0, 0, 6, 4};
    vt[1] = '{1, 2, 1, 2, 24, 16};
    vt[2] = '{10, 13, 20, 22, 60, 36};
    vt[3] = '{5, 4, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 100, 0, 0};
    vt[5] = '{99, 100, 0, 0, 0, 0};
    vt[6] = '{97, 99, 99, 99, 18, 12};
    vt[7] = '{0, 4, 0, 1, 52, 32};

    for (int i = 0; i < 10000; i++) mem[i] = 24'((i % 100) + 16 * (i / 100));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst done", 64'(done), 0);
    chk("rst wren", 64'(bus.wren), 0);
    chk("rst src_rden", 64'(bus.src_rden), 0);
    chk("rst addr", 64'(bus.addr), 0);
    chk("rst wrdata", 64'(bus.wrdata), 0);
    chk("rst src_addr", 64'(bus.src_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle done", 64'(done), 0);

    // 1x1 crop of a known pixel
    mem[0] = 24'h112233;
    run_copy(0, 0, 0, 0, 1'b0, cyc);
    chk("1x1 cycles", 64'(cyc), 6);
    chk("1x1 nbytes", 64'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      chk("1x1 b0", 64'(wlog[0]), 64'({24'd54, 16'h0033}));
      chk("1x1 b1", 64'(wlog[1]), 64'({24'd55, 16'h0022}));
      chk("1x1 b2", 64'(wlog[2]), 64'({24'd56, 16'h0011}));
      chk("1x1 b3", 64'(wlog[3]), 64'({24'd57, 16'h0000}));
    end
    mem[0] = 24'h0;

    // table of geometries, each started from FINISHED
    for (int t = 0; t < 8; t++) begin
      model(vt[t].xa, vt[t].xb, vt[t].ya, vt[t].yb, mcyc);
      run_copy(vt[t].xa, vt[t].xb, vt[t].ya, vt[t].yb, 1'b0, cyc);
      chk($sformatf("vec%0d cycles", t), 64'(cyc), 64'(vt[t].cyc));
      chk($sformatf("vec%0d bytes", t), 64'(wlog.size()), 64'(vt[t].nbytes));
      check_log($sformatf("vec%0d", t));
    end

    // 2x2 layout spot checks
    run_copy(1, 2, 1, 2, 1'b0, cyc);
    if (wlog.size() == 16) begin
      chk("2x2 a54", 64'(wlog[0]), 64'({24'd54, 16'h0021}));
      chk("2x2 a62", 64'(wlog[8]), 64'({24'd62, 16'h0011}));
      chk("2x2 a60", 64'(wlog[6]), 64'({24'd60, 16'h0000}));
      chk("2x2 a61", 64'(wlog[7]), 64'({24'd61, 16'h0000}));
      chk("2x2 a68", 64'(wlog[14]), 64'({24'd68, 16'h0000}));
      chk("2x2 a69", 64'(wlog[15]), 64'({24'd69, 16'h0000}));
    end else begin
      chk("2x2 nbytes", 64'(wlog.size()), 16);
    end

    // 4-wide crop without padding: last address
    run_copy(10, 13, 20, 22, 1'b0, cyc);
    chk("4w last addr", (wlog.size() > 0) ? 64'(wlog[wlog.size()-1][39:16]) : 64'd0, 64'(54 + 36 - 1));

    // randomized geometries with start/bound noise during the copy
    for (int i = 0; i < 10000; i++) mem[i] = 24'($urandom);
    for (int r = 0; r < 24; r++) begin
      int xa, xb, ya, yb;
      xa = $urandom_range(0, 99); xb = xa + $urandom_range(0, 5);
      ya = $urandom_range(0, 99); yb = ya + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin int tmp; tmp = xa; xa = xb + 1; xb = tmp; end
      model(xa, xb, ya, yb, mcyc);
      run_copy(xa, xb, ya, yb, 1'b1, cyc);
      chk($sformatf("rnd%0d cycles", r), 64'(cyc), 64'(mcyc));
      check_log($sformatf("rnd%0d", r));
    end

    // reset during the third green-byte write, then a clean redo
    @(negedge clk);
    wlog.delete();
    xMin = 11'd10; xMax = 11'd13; yMin = 11'd20; yMax = 11'd22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.wren && bus.addr == 24'd61) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst reached WG3", 64'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst done", 64'(done), 0);
    chk("midrst wren", 64'(bus.wren), 0);
    chk("midrst src_rden", 64'(bus.src_rden), 0);
    chk("midrst addr", 64'(bus.addr), 0);
    chk("midrst wrdata", 64'(bus.wrdata), 0);
    chk("midrst src_addr", 64'(bus.src_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle wren", 64'(bus.wren), 0);
    chk("post-rst idle done", 64'(done), 0);
    model(10, 13, 20, 22, mcyc);
    run_copy(10, 13, 20, 22, 1'b0, cyc);
    chk("redo cycles", 64'(cyc), 64'(mcyc));
    check_log("redo");

    // restart from FINISHED with a new geometry
    model(3, 5, 7, 8, mcyc);
    run_copy(3, 5, 7, 8, 1'b0, cyc);
    chk("restart cycles", 64'(cyc), 64'(mcyc));
    check_log("restart");

    chk("no wren/src_rden overlap", 64'(n_overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
